// File: rtl/branch_checkpoint_table_pkg.sv
// Shared sizing and types for the branch checkpoint table.
// Each entry stores the rename map and free-list head captured when a branch is renamed.
package branch_checkpoint_table_pkg;

  localparam int unsigned BRANCH_NUM       = 4;
  localparam int unsigned REG_NUM          = 32;
  localparam int unsigned PHYS_REG_NUM     = 64;
  localparam int unsigned ACTIVE_LIST_SIZE = 32;

  localparam int unsigned BR_IDX   = $clog2(BRANCH_NUM);
  localparam int unsigned PHYS_IDX = $clog2(PHYS_REG_NUM);
  localparam int unsigned AL_IDX   = $clog2(ACTIVE_LIST_SIZE);
  localparam int unsigned RB_W     = REG_NUM * PHYS_IDX;

  typedef struct packed {
    logic [AL_IDX-1:0]   branch_id;
    logic [PHYS_IDX-1:0] free_head_pointer;
    logic [RB_W-1:0]     rename_buffer;
    logic                ds_valid;
  } checkpoint_t;

  function automatic logic [BR_IDX:0] popcount(input logic [BRANCH_NUM-1:0] v);
    logic [BR_IDX:0] n;
    n = '0;
    for (int i = 0; i < BRANCH_NUM; i++) n = n + (BR_IDX+1)'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Returns the index of the first set request bit, scanning from bit 0 when
// BOTTOM_UP is set and from the top bit otherwise.
module priority_encoder #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          BOTTOM_UP = 1'b1,
  localparam int unsigned IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c
);

  always_comb begin
    idx_c   = '0;
    found_c = 1'b0;
    if (BOTTOM_UP) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (req[i] && !found_c) begin
          found_c = 1'b1;
          idx_c   = IDX_W'(i);
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req[i] && !found_c) begin
          found_c = 1'b1;
          idx_c   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/branch_checkpoint_table.sv
// Per-branch rename checkpoints used by misprediction recovery: circular allocation,
// delay-slot refresh of the newest entry, release on correct resolve, restore on mispredict.
module branch_checkpoint_table
  import branch_checkpoint_table_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  alloc_valid,
  input  logic [AL_IDX-1:0]                     alloc_branch_id,
  input  logic [RB_W-1:0]                       alloc_rename_buffer,
  input  logic [PHYS_IDX-1:0]                   alloc_free_head_pointer,
  output logic                                  alloc_ready,
  output logic [BR_IDX-1:0]                     alloc_idx,
  input  logic                                  ds_update_valid,
  input  logic [RB_W-1:0]                       ds_rename_buffer,
  input  logic [PHYS_IDX-1:0]                   ds_free_head_pointer,
  input  logic                                  resolve_valid,
  input  logic [AL_IDX-1:0]                     resolve_branch_id,
  input  logic                                  mispredict,
  input  logic [BRANCH_NUM-1:0]                 recover_valid,
  input  logic [BR_IDX-1:0]                     recover_write_pointer,
  input  logic                                  flush,
  output logic [BRANCH_NUM-1:0]                 valid,
  output logic [BRANCH_NUM*AL_IDX-1:0]          branch_id,
  output logic [BRANCH_NUM*PHYS_IDX-1:0]        free_head_pointer,
  output logic [BRANCH_NUM*RB_W-1:0]            rename_buffer,
  output logic [BRANCH_NUM-1:0]                 ds_valid,
  output logic [BR_IDX-1:0]                     write_pointer,
  output logic [BR_IDX:0]                       count
);

  checkpoint_t             ckpt_q [BRANCH_NUM];
  checkpoint_t             ckpt_d [BRANCH_NUM];
  logic [BRANCH_NUM-1:0]   valid_q, valid_d;
  logic [BR_IDX-1:0]       write_pointer_q, write_pointer_d;
  logic [BR_IDX-1:0]       last_idx_q, last_idx_d;
  logic                    ds_pending_q, ds_pending_d;
  logic [BR_IDX:0]         count_q, count_d;

  logic [BRANCH_NUM-1:0]   match_vec;
  logic [BR_IDX-1:0]       match_idx;
  logic                    match_found;
  logic                    kill;

  always_comb begin
    for (int i = 0; i < BRANCH_NUM; i++)
      match_vec[i] = valid_q[i] && (ckpt_q[i].branch_id == resolve_branch_id);
  end

  priority_encoder #(.WIDTH(BRANCH_NUM), .BOTTOM_UP(1'b1)) u_match_enc (
    .req     (match_vec),
    .idx_c   (match_idx),
    .found_c (match_found)
  );

  assign kill        = resolve_valid && mispredict;
  assign alloc_ready = !valid_q[write_pointer_q];

  always_comb begin
    ckpt_d          = ckpt_q;
    valid_d         = valid_q;
    write_pointer_d = write_pointer_q;
    last_idx_d      = last_idx_q;
    ds_pending_d    = ds_pending_q;

    if (flush) begin
      // Snapshots survive a flush; only the bookkeeping is cleared.
      valid_d         = '0;
      write_pointer_d = '0;
      ds_pending_d    = 1'b0;
      for (int i = 0; i < BRANCH_NUM; i++) ckpt_d[i].ds_valid = 1'b0;
    end else if (kill) begin
      valid_d = recover_valid;
      if (match_found) valid_d[match_idx] = 1'b0;
      write_pointer_d = recover_write_pointer;
      ds_pending_d    = 1'b0;
    end else begin
      // Delay slot targets the previous allocation, before last_idx moves.
      if (ds_update_valid && ds_pending_q && valid_q[last_idx_q]) begin
        ckpt_d[last_idx_q].rename_buffer     = ds_rename_buffer;
        ckpt_d[last_idx_q].free_head_pointer = ds_free_head_pointer;
        ckpt_d[last_idx_q].ds_valid          = 1'b1;
        ds_pending_d                         = 1'b0;
      end
      if (resolve_valid && match_found) valid_d[match_idx] = 1'b0;
      if (alloc_valid && alloc_ready) begin
        valid_d[write_pointer_q]                  = 1'b1;
        ckpt_d[write_pointer_q].branch_id         = alloc_branch_id;
        ckpt_d[write_pointer_q].rename_buffer     = alloc_rename_buffer;
        ckpt_d[write_pointer_q].free_head_pointer = alloc_free_head_pointer;
        ckpt_d[write_pointer_q].ds_valid          = 1'b0;
        write_pointer_d = write_pointer_q + BR_IDX'(1);
        last_idx_d      = write_pointer_q;
        ds_pending_d    = 1'b1;
      end
    end

    count_d = popcount(valid_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BRANCH_NUM; i++) ckpt_q[i] <= '0;
      valid_q         <= '0;
      write_pointer_q <= '0;
      last_idx_q      <= '0;
      ds_pending_q    <= 1'b0;
      count_q         <= '0;
    end else begin
      ckpt_q          <= ckpt_d;
      valid_q         <= valid_d;
      write_pointer_q <= write_pointer_d;
      last_idx_q      <= last_idx_d;
      ds_pending_q    <= ds_pending_d;
      count_q         <= count_d;
    end
  end

  for (genvar g = 0; g < BRANCH_NUM; g++) begin : g_out
    assign branch_id[g*AL_IDX +: AL_IDX]               = ckpt_q[g].branch_id;
    assign free_head_pointer[g*PHYS_IDX +: PHYS_IDX]   = ckpt_q[g].free_head_pointer;
    assign rename_buffer[g*RB_W +: RB_W]               = ckpt_q[g].rename_buffer;
    assign ds_valid[g]                                 = ckpt_q[g].ds_valid;
  end

  assign valid         = valid_q;
  assign write_pointer = write_pointer_q;
  assign alloc_idx     = write_pointer_q;
  assign count         = count_q;

endmodule

// File: tb/tb_branch_checkpoint_table.sv
// Directed checks of the branch checkpoint table with hand-computed expectations.
module tb_branch_checkpoint_table;
  import branch_checkpoint_table_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           alloc_valid;
  logic [AL_IDX-1:0]              alloc_branch_id;
  logic [RB_W-1:0]                alloc_rename_buffer;
  logic [PHYS_IDX-1:0]            alloc_free_head_pointer;
  logic                           alloc_ready;
  logic [BR_IDX-1:0]              alloc_idx;
  logic                           ds_update_valid;
  logic [RB_W-1:0]                ds_rename_buffer;
  logic [PHYS_IDX-1:0]            ds_free_head_pointer;
  logic                           resolve_valid;
  logic [AL_IDX-1:0]              resolve_branch_id;
  logic                           mispredict;
  logic [BRANCH_NUM-1:0]          recover_valid;
  logic [BR_IDX-1:0]              recover_write_pointer;
  logic                           flush;
  logic [BRANCH_NUM-1:0]          valid;
  logic [BRANCH_NUM*AL_IDX-1:0]   branch_id;
  logic [BRANCH_NUM*PHYS_IDX-1:0] free_head_pointer;
  logic [BRANCH_NUM*RB_W-1:0]     rename_buffer;
  logic [BRANCH_NUM-1:0]          ds_valid;
  logic [BR_IDX-1:0]              write_pointer;
  logic [BR_IDX:0]                count;

  int total = 0;
  int bad   = 0;

  branch_checkpoint_table dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_branch_id(alloc_branch_id),
    .alloc_rename_buffer(alloc_rename_buffer), .alloc_free_head_pointer(alloc_free_head_pointer),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .ds_update_valid(ds_update_valid), .ds_rename_buffer(ds_rename_buffer),
    .ds_free_head_pointer(ds_free_head_pointer),
    .resolve_valid(resolve_valid), .resolve_branch_id(resolve_branch_id),
    .mispredict(mispredict), .recover_valid(recover_valid),
    .recover_write_pointer(recover_write_pointer), .flush(flush),
    .valid(valid), .branch_id(branch_id), .free_head_pointer(free_head_pointer),
    .rename_buffer(rename_buffer), .ds_valid(ds_valid),
    .write_pointer(write_pointer), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [RB_W-1:0] pat(input logic [31:0] x);
    return {6{x}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; alloc_valid = 1'b0; alloc_branch_id = '0; alloc_rename_buffer = '0;
    alloc_free_head_pointer = '0; ds_update_valid = 1'b0; ds_rename_buffer = '0;
    ds_free_head_pointer = '0; resolve_valid = 1'b0; resolve_branch_id = '0;
    mispredict = 1'b0; recover_valid = '0; recover_write_pointer = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic set_alloc(input int id, input int head);
    alloc_valid = 1'b1;
    alloc_branch_id = AL_IDX'(id);
    alloc_free_head_pointer = PHYS_IDX'(head);
    alloc_rename_buffer = pat(32'hA5000000 | 32'(id));
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", valid); end
    total++; if (write_pointer !== 2'd0) begin bad++; $display("FAIL reset_wp got=%0d exp=0", write_pointer); end
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", alloc_ready); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
  endtask

  task automatic test_full();
    do_reset();
    set_alloc(3, 1); tick(); set_alloc(5, 2); tick();
    set_alloc(7, 3); tick(); set_alloc(9, 4); tick();
    set_alloc(11, 5); idle();
    total++; if (valid !== 4'b1111) begin bad++; $display("FAIL full_valid got=%b exp=1111", valid); end
    total++; if (write_pointer !== 2'd0) begin bad++; $display("FAIL full_wp got=%0d exp=0", write_pointer); end
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", alloc_ready); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
    total++; if (branch_id !== {5'd9, 5'd7, 5'd5, 5'd3}) begin bad++; $display("FAIL full_ids got=%h exp=%h", branch_id, {5'd9, 5'd7, 5'd5, 5'd3}); end
    set_alloc(11, 5); tick(); idle();
    total++; if (branch_id[4:0] !== 5'd3 || write_pointer !== 2'd0 || count !== 3'd4) begin
      bad++; $display("FAIL full_ignore id0=%0d wp=%0d count=%0d exp id0=3 wp=0 count=4", branch_id[4:0], write_pointer, count); end
  endtask

  task automatic test_ds_update();
    do_reset();
    set_alloc(3, 10); tick(); idle();
    ds_update_valid = 1'b1; ds_free_head_pointer = 6'd12; ds_rename_buffer = pat(32'h0000D512); tick(); idle();
    total++; if (free_head_pointer[5:0] !== 6'd12) begin bad++; $display("FAIL ds_head got=%0d exp=12", free_head_pointer[5:0]); end
    total++; if (ds_valid !== 4'b0001) begin bad++; $display("FAIL ds_valid got=%b exp=0001", ds_valid); end
    total++; if (rename_buffer[RB_W-1:0] !== pat(32'h0000D512)) begin bad++; $display("FAIL ds_rename got=%h", rename_buffer[31:0]); end
    ds_update_valid = 1'b1; ds_free_head_pointer = 6'd20; tick(); idle();
    total++; if (free_head_pointer[5:0] !== 6'd12) begin bad++; $display("FAIL ds_second got=%0d exp=12", free_head_pointer[5:0]); end
    // Alloc entry1, then alloc entry2 together with the delay slot of entry1.
    set_alloc(6, 40); tick();
    set_alloc(8, 50); ds_update_valid = 1'b1; ds_free_head_pointer = 6'd41; tick(); idle();
    total++; if (free_head_pointer[17:0] !== {6'd50, 6'd41, 6'd12}) begin bad++; $display("FAIL ds_same_cycle got=%h exp=%h", free_head_pointer[17:0], {6'd50, 6'd41, 6'd12}); end
    total++; if (ds_valid !== 4'b0011) begin bad++; $display("FAIL ds_same_cycle_flag got=%b exp=0011", ds_valid); end
  endtask

  task automatic test_resolve();
    do_reset();
    set_alloc(3, 1); tick(); set_alloc(5, 2); tick(); set_alloc(7, 3); tick(); idle();
    resolve_valid = 1'b1; resolve_branch_id = 5'd5; tick(); idle();
    total++; if (valid !== 4'b0101) begin bad++; $display("FAIL resolve_valid got=%b exp=0101", valid); end
    total++; if (write_pointer !== 2'd3 || count !== 3'd2) begin bad++; $display("FAIL resolve_wp wp=%0d count=%0d exp wp=3 count=2", write_pointer, count); end
    set_alloc(9, 4); tick(); idle();
    total++; if (valid !== 4'b1101 || branch_id[19:15] !== 5'd9) begin bad++; $display("FAIL resolve_alloc4 valid=%b id3=%0d exp 1101 id3=9", valid, branch_id[19:15]); end
    total++; if (alloc_ready !== 1'b0 || write_pointer !== 2'd0) begin bad++; $display("FAIL resolve_wrap ready=%b wp=%0d exp 0 0", alloc_ready, write_pointer); end
    resolve_valid = 1'b1; resolve_branch_id = 5'd30; tick(); idle();
    total++; if (valid !== 4'b1101) begin bad++; $display("FAIL resolve_nomatch got=%b exp=1101", valid); end
    resolve_valid = 1'b1; resolve_branch_id = 5'd3; tick(); idle();
    total++; if (valid !== 4'b1100 || alloc_ready !== 1'b1) begin bad++; $display("FAIL resolve_hole valid=%b ready=%b exp 1100 1", valid, alloc_ready); end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_alloc(3, 1); tick(); set_alloc(5, 2); tick(); set_alloc(7, 3); tick();
    set_alloc(20, 9);
    resolve_valid = 1'b1; mispredict = 1'b1; resolve_branch_id = 5'd3;
    recover_valid = 4'b0001; recover_write_pointer = 2'd1; tick(); idle();
    total++; if (valid !== 4'b0000 || count !== 3'd0) begin bad++; $display("FAIL mp_valid valid=%b count=%0d exp 0000 0", valid, count); end
    total++; if (write_pointer !== 2'd1 || alloc_ready !== 1'b1) begin bad++; $display("FAIL mp_wp wp=%0d ready=%b exp 1 1", write_pointer, alloc_ready); end
    total++; if (branch_id[19:15] !== 5'd0) begin bad++; $display("FAIL mp_drop id3=%0d exp=0", branch_id[19:15]); end
  endtask

  task automatic test_mispredict_ds();
    do_reset();
    set_alloc(3, 10); tick(); idle();
    ds_update_valid = 1'b1; ds_free_head_pointer = 6'd12; ds_rename_buffer = pat(32'h12121212);
    resolve_valid = 1'b1; mispredict = 1'b1; resolve_branch_id = 5'd17;
    recover_valid = 4'b0001; recover_write_pointer = 2'd1; tick(); idle();
    total++; if (free_head_pointer[5:0] !== 6'd10 || ds_valid !== 4'b0000) begin bad++; $display("FAIL mpds_snap head=%0d dsv=%b exp 10 0000", free_head_pointer[5:0], ds_valid); end
    total++; if (rename_buffer[RB_W-1:0] !== pat(32'hA5000003) || valid !== 4'b0001) begin bad++; $display("FAIL mpds_rename valid=%b exp 0001", valid); end
    ds_update_valid = 1'b1; ds_free_head_pointer = 6'd14; tick(); idle();
    total++; if (free_head_pointer[5:0] !== 6'd10 || ds_valid !== 4'b0000) begin bad++; $display("FAIL mpds_pending head=%0d dsv=%b exp 10 0000", free_head_pointer[5:0], ds_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    set_alloc(3, 10); tick(); idle();
    ds_update_valid = 1'b1; ds_free_head_pointer = 6'd11; tick(); idle();
    set_alloc(4, 15); flush = 1'b1;
    resolve_valid = 1'b1; mispredict = 1'b1; recover_valid = 4'b0011; recover_write_pointer = 2'd2; tick(); idle();
    total++; if (valid !== 4'b0000 || write_pointer !== 2'd0 || count !== 3'd0) begin bad++; $display("FAIL flush_state valid=%b wp=%0d count=%0d exp 0000 0 0", valid, write_pointer, count); end
    total++; if (ds_valid !== 4'b0000 || free_head_pointer[11:0] !== {6'd0, 6'd11} || branch_id[4:0] !== 5'd3) begin
      bad++; $display("FAIL flush_keep dsv=%b heads=%h id0=%0d exp 0000 00b 3", ds_valid, free_head_pointer[11:0], branch_id[4:0]); end
  endtask

  task automatic test_reset_alloc();
    do_reset();
    set_alloc(3, 1); tick();
    set_alloc(5, 2); rst = 1'b1; tick(); idle();
    total++; if (valid !== 4'b0000 || write_pointer !== 2'd0 || alloc_ready !== 1'b1) begin
      bad++; $display("FAIL rst_alloc valid=%b wp=%0d ready=%b exp 0000 0 1", valid, write_pointer, alloc_ready); end
    total++; if (branch_id !== '0 || count !== 3'd0) begin bad++; $display("FAIL rst_alloc_ids ids=%h count=%0d exp 0 0", branch_id, count); end
  endtask

  initial begin
    idle();
    test_reset();
    test_full();
    test_ds_update();
    test_resolve();
    test_mispredict();
    test_mispredict_ds();
    test_flush();
    test_reset_alloc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
